// File: rtl/dm_arbiter.sv
// ============================================================================
// dm_arbiter
// ----------------------------------------------------------------------------
// Shares a single-port 32-bit word memory between two requesters:
// A (CPU load/store unit) and B (debug/DMA port). Requesters take turns
// under round-robin priority. The block extracts lb/lh/lw/lbu/lhu results
// from the addressed lane. Sub-word stores are done as an atomic two-cycle
// read-modify-write, so the memory only ever receives full-word writes.
//
// Ports:
//   clk, rst                clock, asynchronous active-low reset
//   a_* / b_*               per-requester handshake:
//                           req/we/dop/addr/wdata in;
//                           gnt/done/err/rdata out
//   mem_addr/we/wdata       word-array write side and address
//   mem_rdata               combinational read data for mem_addr
// ============================================================================
module dm_arbiter #(
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [2:0]    a_dop,
    input  logic [31:0]   a_addr,
    input  logic [31:0]   a_wdata,
    output logic          a_gnt,
    output logic          a_done,
    output logic          a_err,
    output logic [31:0]   a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [2:0]    b_dop,
    input  logic [31:0]   b_addr,
    input  logic [31:0]   b_wdata,
    output logic          b_gnt,
    output logic          b_done,
    output logic          b_err,
    output logic [31:0]   b_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR, DONE} state_t;

    // Requester identity: 0 = A, 1 = B
    localparam logic ID_B = 1'b1;

    state_t      state;
    logic        last_id;
    logic        id_reg;
    logic        we_reg;
    logic        err_reg;
    logic [2:0]  dop_reg;
    logic [1:0]  off_reg;
    logic [15:0] wdata_reg;

    logic        grant_any;
    logic        sel_b;
    logic        sel_we;
    logic [2:0]  sel_dop;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_err;
    logic [31:0] ld_val;

    // Word-address bits above the array are never routed to memory
    logic unused_addr_bits;
    assign unused_addr_bits = ^{a_addr[31:AW+2], b_addr[31:AW+2]};

    function automatic logic illegal(input logic we, input logic [2:0] dop,
                                     input logic [1:0] off);
        logic r;
        case (dop)
            3'd0:    r = 1'b0;
            3'd1:    r = off[0];
            3'd2:    r = (off != 2'b00);
            3'd4:    r = we;
            3'd5:    r = we | off[0];
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] dop,
                                            input logic [1:0] off,
                                            input logic [31:0] word);
        logic [7:0]  bv;
        logic [15:0] hv;
        logic [31:0] r;
        bv = word[{off, 3'b000} +: 8];
        hv = word[{off[1], 4'b0000} +: 16];
        case (dop)
            3'd0:    r = {{24{bv[7]}}, bv};
            3'd1:    r = {{16{hv[15]}}, hv};
            3'd4:    r = {24'h0, bv};
            3'd5:    r = {16'h0, hv};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace only the addressed byte/half lane of the word just read
    function automatic logic [31:0] merge_lane(input logic [2:0] dop,
                                               input logic [1:0] off,
                                               input logic [31:0] word,
                                               input logic [15:0] wd);
        logic [31:0] r;
        r = word;
        if (dop == 3'd0)
            r[{off, 3'b000} +: 8] = wd[7:0];
        else
            r[{off[1], 4'b0000} +: 16] = wd;
        return r;
    endfunction

    // Winner selection: on contention, the requester that was not granted
    // last wins. The grant is combinational and only issued in IDLE.
    always_comb begin
        grant_any = rst && (state == IDLE) && (a_req || b_req);
        if (a_req && b_req)
            sel_b = (last_id != ID_B);
        else
            sel_b = b_req;
        a_gnt     = grant_any && !sel_b;
        b_gnt     = grant_any && sel_b;
        sel_we    = sel_b ? b_we    : a_we;
        sel_dop   = sel_b ? b_dop   : a_dop;
        sel_addr  = sel_b ? b_addr  : a_addr;
        sel_wdata = sel_b ? b_wdata : a_wdata;
        sel_err   = illegal(sel_we, sel_dop, sel_addr[1:0]);
        ld_val    = (err_reg || we_reg) ? 32'h0
                                        : extract(dop_reg, off_reg, mem_rdata);
    end

    // Sequencer. Memory-side outputs are set up on the edge that enters a
    // state, so a full-word store already writes during ACCESS. A sub-word
    // store writes its merged word during MERGE_WR.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            last_id   <= ID_B;
            id_reg    <= 1'b0;
            we_reg    <= 1'b0;
            err_reg   <= 1'b0;
            dop_reg   <= 3'd0;
            off_reg   <= 2'd0;
            wdata_reg <= 16'h0;
            a_done    <= 1'b0;
            a_err     <= 1'b0;
            a_rdata   <= 32'h0;
            b_done    <= 1'b0;
            b_err     <= 1'b0;
            b_rdata   <= 32'h0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        id_reg    <= sel_b;
                        last_id   <= sel_b;
                        we_reg    <= sel_we;
                        err_reg   <= sel_err;
                        dop_reg   <= sel_dop;
                        off_reg   <= sel_addr[1:0];
                        wdata_reg <= sel_wdata[15:0];
                        mem_addr  <= sel_addr[AW+1:2];
                        if (!sel_err && sel_we && sel_dop == 3'd2) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= sel_wdata;
                        end
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_we    <= 1'b0;
                    mem_wdata <= 32'h0;
                    if (!err_reg && we_reg && dop_reg != 3'd2) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= merge_lane(dop_reg, off_reg, mem_rdata, wdata_reg);
                        state     <= MERGE_WR;
                    end else begin
                        if (id_reg == ID_B) begin
                            b_done  <= 1'b1;
                            b_err   <= err_reg;
                            b_rdata <= ld_val;
                        end else begin
                            a_done  <= 1'b1;
                            a_err   <= err_reg;
                            a_rdata <= ld_val;
                        end
                        state <= DONE;
                    end
                end
                MERGE_WR: begin
                    mem_we    <= 1'b0;
                    mem_wdata <= 32'h0;
                    if (id_reg == ID_B) begin
                        b_done  <= 1'b1;
                        b_rdata <= 32'h0;
                    end else begin
                        a_done  <= 1'b1;
                        a_rdata <= 32'h0;
                    end
                    state <= DONE;
                end
                DONE: begin
                    a_done   <= 1'b0;
                    a_err    <= 1'b0;
                    b_done   <= 1'b0;
                    b_err    <= 1'b0;
                    mem_addr <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// ============================================================================
// tb_dm_arbiter
// ----------------------------------------------------------------------------
// Self-checking bench for dm_arbiter. It contains a 32x32 word memory
// model, a table of single-requester accesses, and hand-written sequences.
// The sequences cover reset during a read-modify-write and round-robin
// contention. The expected completion of each access is queued when the
// access is driven, then popped and compared when a done pulse appears.
// ============================================================================
module tb_dm_arbiter;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          a_req = 1'b0, a_we = 1'b0;
    logic [2:0]    a_dop = 3'd0;
    logic [31:0]   a_addr = 32'h0, a_wdata = 32'h0;
    logic          a_gnt, a_done, a_err;
    logic [31:0]   a_rdata;
    logic          b_req = 1'b0, b_we = 1'b0;
    logic [2:0]    b_dop = 3'd0;
    logic [31:0]   b_addr = 32'h0, b_wdata = 32'h0;
    logic          b_gnt, b_done, b_err;
    logic [31:0]   b_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    logic [31:0]   mem [0:31];

    dm_arbiter #(.AW(AW)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_dop(a_dop), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_gnt(a_gnt), .a_done(a_done), .a_err(a_err),
        .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_dop(b_dop), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_gnt(b_gnt), .b_done(b_done), .b_err(b_err),
        .b_rdata(b_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    typedef struct {
        logic        who;
        logic        we;
        logic [2:0]  dop;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          wes;
    } vec_t;

    typedef struct {
        logic        who;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          wes;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[$];
    int   n_vec = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   gnt_cyc = 0;
    int   we_cnt = 0;

    always @(posedge clk) cyc++;

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        n_vec++;
        n_fail++;
        $display("[TB] FAIL %s: got timeout/unexpected event, expected none", name);
    endtask

    // Monitor: tracks grant time and write pulses, and scores each completion
    always @(negedge clk) begin
        if (rst) begin
            if (a_gnt || b_gnt) begin
                gnt_cyc = cyc;
                we_cnt  = 0;
            end
            if (mem_we) we_cnt++;
            if (a_done && b_done) flag_fail("double_done");
            if (a_done || b_done) begin
                if (sb.size() == 0) begin
                    flag_fail("unexpected_done");
                end else begin
                    mon_e = sb.pop_front();
                    check_output("done_id", {31'b0, b_done}, {31'b0, mon_e.who});
                    check_output("rdata", b_done ? b_rdata : a_rdata, mon_e.rdata);
                    check_output("err", {31'b0, b_done ? b_err : a_err}, {31'b0, mon_e.err});
                    check_output("latency", cyc - gnt_cyc, mon_e.lat);
                    check_output("mem_we_count", we_cnt, mon_e.wes);
                end
            end
        end
    end

    task automatic wait_drain();
        for (int t = 0; t < 20 && sb.size() != 0; t++) @(negedge clk);
        if (sb.size() != 0) begin
            flag_fail("drain_timeout");
            sb.delete();
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        exp_t e;
        logic got;
        @(posedge clk); #1;
        e = '{v.who, v.rdata, v.err, v.lat, v.wes};
        sb.push_back(e);
        if (!v.who) begin
            a_req = 1'b1; a_we = v.we; a_dop = v.dop; a_addr = v.addr; a_wdata = v.wdata;
        end else begin
            b_req = 1'b1; b_we = v.we; b_dop = v.dop; b_addr = v.addr; b_wdata = v.wdata;
        end
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            got = v.who ? b_gnt : a_gnt;
        end
        if (!got) flag_fail("gnt_timeout");
        @(posedge clk); #1;
        a_req = 1'b0;
        b_req = 1'b0;
        wait_drain();
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_gnt"},   {30'b0, a_gnt, b_gnt}, 32'h0);
        check_output({tag, "_done"},  {28'b0, a_done, b_done, a_err, b_err}, 32'h0);
        check_output({tag, "_rdata"}, a_rdata | b_rdata, 32'h0);
        check_output({tag, "_mem"},   {26'b0, mem_addr, mem_we}, 32'h0);
        check_output({tag, "_wdata"}, mem_wdata, 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic got;
        int   prev;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mem[1] = 32'h12345678;

        // Reset state, with a request held high to show no grant leaks out
        a_req = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        a_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;

        // Reset during MERGE_WR abandons the sub-word store
        @(posedge clk); #1;
        b_req = 1'b1; b_we = 1'b1; b_dop = 3'd0; b_addr = 32'h4; b_wdata = 32'hAA;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            got = b_gnt;
        end
        if (!got) flag_fail("rmw_gnt_timeout");
        @(posedge clk); #1;
        b_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("mid_rmw_reset");
        check_output("mid_rmw_we_count", we_cnt, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        check_output("mid_rmw_word1", mem[1], 32'h12345678);

        // who we  dop  addr   wdata         rdata         err lat wes
        vecs.push_back('{1'b0, 1'b1, 3'd2, 32'h8, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1});
        vecs.push_back('{1'b0, 1'b0, 3'd0, 32'hB, 32'h0,        32'hFFFFFFDE, 1'b0, 2, 0});
        vecs.push_back('{1'b0, 1'b0, 3'd4, 32'hB, 32'h0,        32'h000000DE, 1'b0, 2, 0});
        vecs.push_back('{1'b0, 1'b0, 3'd1, 32'hA, 32'h0,        32'hFFFFDEAD, 1'b0, 2, 0});
        vecs.push_back('{1'b0, 1'b0, 3'd5, 32'hA, 32'h0,        32'h0000DEAD, 1'b0, 2, 0});
        vecs.push_back('{1'b0, 1'b0, 3'd2, 32'h8, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0});
        vecs.push_back('{1'b1, 1'b1, 3'd2, 32'h8, 32'h11223344, 32'h0,        1'b0, 2, 1});
        vecs.push_back('{1'b1, 1'b1, 3'd0, 32'h9, 32'hCAFE0077, 32'h0,        1'b0, 3, 1});
        vecs.push_back('{1'b1, 1'b0, 3'd2, 32'h8, 32'h0,        32'h11227744, 1'b0, 2, 0});
        vecs.push_back('{1'b1, 1'b1, 3'd1, 32'hA, 32'h1234BEEF, 32'h0,        1'b0, 3, 1});
        vecs.push_back('{1'b1, 1'b0, 3'd2, 32'h8, 32'h0,        32'hBEEF7744, 1'b0, 2, 0});
        vecs.push_back('{1'b0, 1'b0, 3'd2, 32'h2, 32'h0,        32'h0,        1'b1, 2, 0});
        vecs.push_back('{1'b0, 1'b0, 3'd1, 32'h1, 32'h0,        32'h0,        1'b1, 2, 0});
        vecs.push_back('{1'b0, 1'b0, 3'd3, 32'h8, 32'h0,        32'h0,        1'b1, 2, 0});
        vecs.push_back('{1'b0, 1'b1, 3'd4, 32'h8, 32'h55,       32'h0,        1'b1, 2, 0});
        vecs.push_back('{1'b1, 1'b0, 3'd6, 32'h8, 32'h0,        32'h0,        1'b1, 2, 0});
        vecs.push_back('{1'b0, 1'b1, 3'd1, 32'h3, 32'h9999,     32'h0,        1'b1, 2, 0});
        vecs.push_back('{1'b1, 1'b0, 3'd2, 32'h8, 32'h0,        32'hBEEF7744, 1'b0, 2, 0});
        vecs.push_back('{1'b0, 1'b0, 3'd1, 32'h8, 32'h0,        32'h00007744, 1'b0, 2, 0});
        vecs.push_back('{1'b0, 1'b0, 3'd4, 32'h9, 32'h0,        32'h00000077, 1'b0, 2, 0});
        vecs.push_back('{1'b0, 1'b0, 3'd0, 32'hA, 32'h0,        32'hFFFFFFEF, 1'b0, 2, 0});
        vecs.push_back('{1'b1, 1'b0, 3'd2, 32'h8, 32'h0,        32'hBEEF7744, 1'b0, 2, 0});

        foreach (vecs[i]) apply_stimulus(vecs[i]);

        @(negedge clk);
        check_output("a_rdata_hold", a_rdata, 32'hFFFFFFEF);
        check_output("word2_final", mem[2], 32'hBEEF7744);
        check_output("word1_untouched", mem[1], 32'h12345678);

        // Contention after a fresh reset: grants alternate A,B,A,B
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) sb.push_back('{k[0], 32'h0, 1'b0, 2, 1});
        a_req = 1'b1; a_we = 1'b1; a_dop = 3'd2; a_addr = 32'h10; a_wdata = 32'hA0A0A0A0;
        b_req = 1'b1; b_we = 1'b1; b_dop = 3'd2; b_addr = 32'h14; b_wdata = 32'hB0B0B0B0;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int t = 0; t < 20 && !got; t++) begin
                @(negedge clk);
                got = a_gnt || b_gnt;
            end
            if (!got) begin
                flag_fail("rr_gnt_timeout");
                break;
            end
            check_output("rr_gnt_id", {30'b0, a_gnt, b_gnt}, k[0] ? 32'h1 : 32'h2);
            if (k > 0) check_output("rr_gnt_spacing", cyc - prev, 32'd3);
            prev = cyc;
        end
        @(posedge clk); #1;
        a_req = 1'b0;
        b_req = 1'b0;
        wait_drain();
        check_output("rr_word4", mem[4], 32'hA0A0A0A0);
        check_output("rr_word5", mem[5], 32'hB0B0B0B0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
